// File: rtl/riscv_pipe_pkg.sv
// Shared types for the RV64 pipeline hazard/forwarding controller.
package riscv_pipe_pkg;

    localparam int unsigned REG_AW = 5;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        HzRun,
        HzLoadStall,
        HzMemWait
    } hz_state_t;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic              memread;
        logic              memop;
    } stage_shadow_t;

endpackage

// File: rtl/fwd_compare.sv
// Per-operand forwarding select: the MEM producer beats the WB producer, and x0 never forwards.
module fwd_compare
    import riscv_pipe_pkg::*;
(
    input  logic [REG_AW-1:0] src,
    input  stage_shadow_t     mem_sh,
    input  stage_shadow_t     wb_sh,
    output fwd_sel_t          sel
);

    logic mem_hit;
    logic wb_hit;
    logic unused_fields;

    assign mem_hit = mem_sh.valid && mem_sh.regwrite && (mem_sh.rd != '0) && (mem_sh.rd == src);
    assign wb_hit  = wb_sh.valid && wb_sh.regwrite && (wb_sh.rd != '0) && (wb_sh.rd == src);

    assign unused_fields = ^{mem_sh.memread, mem_sh.memop, wb_sh.memread, wb_sh.memop};

    always_comb begin
        sel = FWD_RF;
        if (mem_hit) begin
            sel = FWD_MEM;
        end else if (wb_hit) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard controller: EX/MEM/WB shadows, operand forwarding, load-use stall, flush, dmem freeze.
// Forwarding is built only when HAZARD_FWD_EN is defined; otherwise RAW hazards stall instead.
module hazard_fwd_ctrl
    import riscv_pipe_pkg::*;
#(
    parameter int unsigned REG_AW = riscv_pipe_pkg::REG_AW,
    parameter int unsigned XLEN   = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              id_memop,
    input  logic              branch_taken,
    input  logic              dmem_ready,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              pc_we,
    output logic              ifid_we,
    output logic              ifid_clr,
    output logic              idex_clr,
    output logic              pipe_freeze
);

    stage_shadow_t     ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    logic [REG_AW-1:0] ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d;
    hz_state_t         state_q, state_d;

    logic      mem_wait;
    logic      freeze;
    logic      raw_stall;
    logic      advance;
    logic      bubble;
    hz_state_t run_next;
    logic      unused_cfg;

    function automatic logic id_reads(stage_shadow_t s, logic [REG_AW-1:0] rs1,
                                      logic [REG_AW-1:0] rs2);
        return (s.rd != '0) && ((s.rd == rs1) || (s.rd == rs2));
    endfunction

    assign mem_wait = mem_q.valid && mem_q.memop && !dmem_ready;

`ifdef HAZARD_FWD_EN
    fwd_sel_t fwd_a, fwd_b;

    fwd_compare u_fwd_a (
        .src    (ex_rs1_q),
        .mem_sh (mem_q),
        .wb_sh  (wb_q),
        .sel    (fwd_a)
    );

    fwd_compare u_fwd_b (
        .src    (ex_rs2_q),
        .mem_sh (mem_q),
        .wb_sh  (wb_q),
        .sel    (fwd_b)
    );

    assign fwd_a_sel  = fwd_a;
    assign fwd_b_sel  = fwd_b;
    assign raw_stall  = id_valid && ex_q.valid && ex_q.memread && id_reads(ex_q, id_rs1, id_rs2);
    assign unused_cfg = XLEN[0];
`else
    // Without forwarding any in-flight producer in EX or MEM must drain; WB is write-first.
    assign fwd_a_sel  = FWD_RF;
    assign fwd_b_sel  = FWD_RF;
    assign raw_stall  = id_valid &&
                        ((ex_q.valid && ex_q.regwrite && id_reads(ex_q, id_rs1, id_rs2)) ||
                         (mem_q.valid && mem_q.regwrite && id_reads(mem_q, id_rs1, id_rs2)));
    assign unused_cfg = ^{XLEN[0], wb_q, ex_rs1_q, ex_rs2_q};
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= HzRun;
            ex_q     <= '0;
            mem_q    <= '0;
            wb_q     <= '0;
            ex_rs1_q <= '0;
            ex_rs2_q <= '0;
        end else begin
            state_q  <= state_d;
            ex_q     <= ex_d;
            mem_q    <= mem_d;
            wb_q     <= wb_d;
            ex_rs1_q <= ex_rs1_d;
            ex_rs2_q <= ex_rs2_d;
        end
    end

    assign run_next = branch_taken ? HzRun : (raw_stall ? HzLoadStall : HzRun);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            HzRun, HzLoadStall: state_d = mem_wait ? HzMemWait : run_next;
            HzMemWait:          state_d = dmem_ready ? run_next : HzMemWait;
            default:            state_d = HzRun;
        endcase
    end

    // The cycle dmem_ready rises in MEM_WAIT advances normally.
    assign freeze = (state_q == HzMemWait) ? !dmem_ready : mem_wait;

    always_comb begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        ifid_clr    = 1'b0;
        idex_clr    = 1'b0;
        pipe_freeze = 1'b0;
        advance     = 1'b1;
        bubble      = 1'b0;
        if (freeze) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            pipe_freeze = 1'b1;
            advance     = 1'b0;
        end else if (branch_taken) begin
            ifid_clr = 1'b1;
            idex_clr = 1'b1;
            bubble   = 1'b1;
        end else if (raw_stall) begin
            pc_we    = 1'b0;
            ifid_we  = 1'b0;
            idex_clr = 1'b1;
            bubble   = 1'b1;
        end
    end

    always_comb begin
        ex_d     = ex_q;
        mem_d    = mem_q;
        wb_d     = wb_q;
        ex_rs1_d = ex_rs1_q;
        ex_rs2_d = ex_rs2_q;
        if (advance) begin
            mem_d = ex_q;
            wb_d  = mem_q;
            if (bubble) begin
                ex_d     = '0;
                ex_rs1_d = '0;
                ex_rs2_d = '0;
            end else begin
                ex_d = '{valid: id_valid, rd: id_rd, regwrite: id_regwrite,
                         memread: id_memread, memop: id_memop};
                ex_rs1_d = id_rs1;
                ex_rs2_d = id_rs2;
            end
        end
    end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Scoreboard bench for hazard_fwd_ctrl; expectations follow the HAZARD_FWD_EN build setting.
module tb_hazard_fwd_ctrl;

`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct packed {
        logic       v;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
        logic       mo;
    } instr_t;

    typedef struct {
        string      nm;
        logic [8:0] exp;
    } item_t;

    // Control field order: {pc_we, ifid_we, ifid_clr, idex_clr, pipe_freeze}
    localparam logic [4:0] NRM = 5'b11000;
    localparam logic [4:0] STL = 5'b00010;
    localparam logic [4:0] FLS = 5'b11110;
    localparam logic [4:0] FRZ = 5'b00001;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid, id_regwrite, id_memread, id_memop, branch_taken, dmem_ready;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    logic       pc_we, ifid_we, ifid_clr, idex_clr, pipe_freeze;

    item_t q[$];
    int    total = 0;
    int    bad = 0;

    hazard_fwd_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rd        (id_rd),
        .id_regwrite  (id_regwrite),
        .id_memread   (id_memread),
        .id_memop     (id_memop),
        .branch_taken (branch_taken),
        .dmem_ready   (dmem_ready),
        .fwd_a_sel    (fwd_a_sel),
        .fwd_b_sel    (fwd_b_sel),
        .pc_we        (pc_we),
        .ifid_we      (ifid_we),
        .ifid_clr     (ifid_clr),
        .idex_clr     (idex_clr),
        .pipe_freeze  (pipe_freeze)
    );

    always #5 clk = ~clk;

    function automatic instr_t nop();
        return '0;
    endfunction

    function automatic instr_t alu(input logic [4:0] rd, input logic [4:0] rs1,
                                   input logic [4:0] rs2);
        return '{v: 1'b1, rs1: rs1, rs2: rs2, rd: rd, rw: 1'b1, mr: 1'b0, mo: 1'b0};
    endfunction

    function automatic instr_t ld(input logic [4:0] rd, input logic [4:0] rs1);
        return '{v: 1'b1, rs1: rs1, rs2: 5'd0, rd: rd, rw: 1'b1, mr: 1'b1, mo: 1'b1};
    endfunction

    function automatic instr_t sd(input logic [4:0] rs1, input logic [4:0] rs2);
        return '{v: 1'b1, rs1: rs1, rs2: rs2, rd: 5'd0, rw: 1'b0, mr: 1'b0, mo: 1'b1};
    endfunction

    // One cycle: drive ID and side inputs, queue the expected outputs, advance past the edge.
    task automatic step(input string nm, input instr_t ins, input logic br, input logic dr,
                        input logic [1:0] a, input logic [1:0] b, input logic [4:0] ctl);
        item_t it;
        id_valid     = ins.v;
        id_rs1       = ins.rs1;
        id_rs2       = ins.rs2;
        id_rd        = ins.rd;
        id_regwrite  = ins.rw;
        id_memread   = ins.mr;
        id_memop     = ins.mo;
        branch_taken = br;
        dmem_ready   = dr;
        it.nm        = nm;
        it.exp       = {a, b, ctl};
        q.push_back(it);
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 3; i++) step(nm, nop(), 1'b0, 1'b1, 2'b00, 2'b00, NRM);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            item_t      it;
            logic [8:0] got;
            it  = q.pop_front();
            got = {fwd_a_sel, fwd_b_sel, pc_we, ifid_we, ifid_clr, idex_clr, pipe_freeze};
            total++;
            if (got !== it.exp) begin
                bad++;
                $display("FAIL %s: got a/b/pc/ifwe/ifclr/idclr/frz=%b required=%b",
                         it.nm, got, it.exp);
            end
        end
    end

    initial begin
        rst_n        = 1'b0;
        id_valid     = 1'b0;
        id_rs1       = '0;
        id_rs2       = '0;
        id_rd        = '0;
        id_regwrite  = 1'b0;
        id_memread   = 1'b0;
        id_memop     = 1'b0;
        branch_taken = 1'b0;
        dmem_ready   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        step("reset", nop(), 1'b0, 1'b1, 2'b00, 2'b00, NRM);

`ifdef HAZARD_FWD_EN
        step("fwd_p", alu(5, 0, 0), 1'b0, 1'b1, 2'b00, 2'b00, NRM);
        step("fwd_c", alu(6, 5, 1), 1'b0, 1'b1, 2'b00, 2'b00, NRM);
        step("fwd_mem", nop(), 1'b0, 1'b1, 2'b10, 2'b00, NRM);
        drain("fwd_drain");
        step("prio_p1", alu(5, 0, 0), 1'b0, 1'b1, 2'b00, 2'b00, NRM);
        step("prio_p2", alu(5, 0, 0), 1'b0, 1'b1, 2'b00, 2'b00, NRM);
        step("prio_c", alu(6, 5, 5), 1'b0, 1'b1, 2'b00, 2'b00, NRM);
        step("prio_mem", nop(), 1'b0, 1'b1, 2'b10, 2'b10, NRM);
        drain("prio_drain");
        step("wb_p5", alu(5, 0, 0), 1'b0, 1'b1, 2'b00, 2'b00, NRM);
        step("wb_p9", alu(9, 0, 0), 1'b0, 1'b1, 2'b00, 2'b00, NRM);
        step("wb_c", alu(6, 5, 9), 1'b0, 1'b1, 2'b00, 2'b00, NRM);
        step("wb_mix", nop(), 1'b0, 1'b1, 2'b01, 2'b10, NRM);
        drain("wb_drain");
        step("lu_ld", ld(7, 2), 1'b0, 1'b1, 2'b00, 2'b00, NRM);
        step("lu_stall", alu(8, 7, 7), 1'b0, 1'b1, 2'b00, 2'b00, STL);
        step("lu_after", alu(8, 7, 7), 1'b0, 1'b1, 2'b00, 2'b00, NRM);
        step("lu_fwd_wb", nop(), 1'b0, 1'b1, 2'b01, 2'b01, NRM);
        drain("lu_drain");
`else
        step("raw_p", alu(5, 0, 0), 1'b0, 1'b1, 2'b00, 2'b00, NRM);
        step("raw_stall_ex", alu(6, 5, 1), 1'b0, 1'b1, 2'b00, 2'b00, STL);
        step("raw_stall_mem", alu(6, 5, 1), 1'b0, 1'b1, 2'b00, 2'b00, STL);
        step("raw_release", alu(6, 5, 1), 1'b0, 1'b1, 2'b00, 2'b00, NRM);
        step("raw_exec", nop(), 1'b0, 1'b1, 2'b00, 2'b00, NRM);
        drain("raw_drain");
        step("lu_ld", ld(7, 2), 1'b0, 1'b1, 2'b00, 2'b00, NRM);
        step("lu_stall_ex", alu(8, 7, 7), 1'b0, 1'b1, 2'b00, 2'b00, STL);
        step("lu_stall_mem", alu(8, 7, 7), 1'b0, 1'b1, 2'b00, 2'b00, STL);
        step("lu_release", alu(8, 7, 7), 1'b0, 1'b1, 2'b00, 2'b00, NRM);
        drain("lu_drain");
`endif

        step("x0_w", alu(0, 1, 1), 1'b0, 1'b1, 2'b00, 2'b00, NRM);
        step("x0_c", alu(3, 0, 0), 1'b0, 1'b1, 2'b00, 2'b00, NRM);
        step("x0_nofwd", nop(), 1'b0, 1'b1, 2'b00, 2'b00, NRM);
        step("x0_ld", ld(0, 2), 1'b0, 1'b1, 2'b00, 2'b00, NRM);
        step("x0_nostall", alu(3, 0, 0), 1'b0, 1'b1, 2'b00, 2'b00, NRM);
        step("x0_ld_nofwd", nop(), 1'b0, 1'b1, 2'b00, 2'b00, NRM);
        drain("x0_drain");

        step("mw_p4", alu(4, 0, 0), 1'b0, 1'b1, 2'b00, 2'b00, NRM);
        step("mw_sd", sd(2, 1), 1'b0, 1'b1, 2'b00, 2'b00, NRM);
        step("mw_c", alu(11, 4, 0), 1'b0, 1'b1, 2'b00, 2'b00, FWD ? NRM : STL);
        step("mw_frz1", alu(11, 4, 0), 1'b0, 1'b0, FWD ? 2'b01 : 2'b00, 2'b00, FRZ);
        step("mw_frz2_br", alu(11, 4, 0), 1'b1, 1'b0, FWD ? 2'b01 : 2'b00, 2'b00, FRZ);
        step("mw_frz3", alu(11, 4, 0), 1'b0, 1'b0, FWD ? 2'b01 : 2'b00, 2'b00, FRZ);
        step("mw_release", alu(11, 4, 0), 1'b0, 1'b1, FWD ? 2'b01 : 2'b00, 2'b00, NRM);
        step("mw_after", nop(), 1'b0, 1'b1, 2'b00, 2'b00, NRM);
        drain("mw_drain");

        step("br_ld", ld(7, 2), 1'b0, 1'b1, 2'b00, 2'b00, NRM);
        step("br_flush", alu(8, 7, 7), 1'b1, 1'b1, 2'b00, 2'b00, FLS);
        step("br_next", alu(8, 7, 7), 1'b0, 1'b1, 2'b00, 2'b00, FWD ? NRM : STL);
        step("br_use", alu(8, 7, 7), 1'b0, 1'b1, FWD ? 2'b01 : 2'b00, FWD ? 2'b01 : 2'b00, NRM);
        step("br_end", nop(), 1'b0, 1'b1, 2'b00, 2'b00, NRM);
        drain("br_drain");

        step("rst_sd", sd(2, 1), 1'b0, 1'b1, 2'b00, 2'b00, NRM);
        step("rst_gap", nop(), 1'b0, 1'b1, 2'b00, 2'b00, NRM);
        step("rst_frz", nop(), 1'b0, 1'b0, 2'b00, 2'b00, FRZ);
        rst_n = 1'b0;
        step("rst_frz_hold", nop(), 1'b0, 1'b0, 2'b00, 2'b00, FRZ);
        rst_n = 1'b1;
        step("rst_clear", nop(), 1'b0, 1'b0, 2'b00, 2'b00, NRM);
        step("rst_idle", nop(), 1'b0, 1'b1, 2'b00, 2'b00, NRM);

        for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() > 0) begin
            bad++;
            $display("FAIL drain_queue: got %0d pending, required 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_fwd_ctrl.md
# hazard_fwd_ctrl

Pipeline hazard controller for the 5-stage 64-bit RV64 core. It tracks the destination-register state of the EX, MEM and WB stages in its own shadow registers. From that state it drives the 2-bit select of both ALU-operand forwarding muxes (3:1, 64-bit) and generates the load-use stall, branch flush and data-memory wait freeze. It sits beside the ID/EX boundary and owns every pipeline-register enable and clear.

## Interface
Parameters:
- REG_AW, 5, register-index width
- XLEN, 64, datapath width (documentation only; no data flows through this block)

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset; synchronous, active-low
- id_valid  in  1  ID holds a real instruction
- id_rs1, id_rs2  in  REG_AW  source indices of the ID instruction
- id_rd  in  REG_AW  destination index of the ID instruction
- id_regwrite  in  1  ID instruction writes rd
- id_memread  in  1  ID instruction is a load
- id_memop  in  1  ID instruction is a load or store
- branch_taken  in  1  EX resolved a taken branch or jump this cycle
- dmem_ready  in  1  data memory completes the MEM-stage access this cycle
- fwd_a_sel, fwd_b_sel  out  2  operand mux selects: 00 regfile, 01 WB value, 10 EX/MEM ALU result; 11 never driven
- pc_we  out  1  PC write enable
- ifid_we  out  1  IF/ID register enable
- ifid_clr  out  1  IF/ID synchronous clear
- idex_clr  out  1  ID/EX clear (bubble)
- pipe_freeze  out  1  hold ID/EX, EX/MEM and MEM/WB

## Operation
- Shadow stages EX, MEM and WB each hold {valid, rd, regwrite, memread, memop}.
  - On advance: EX←ID fields (valid forced 0 on bubble or flush), MEM←EX, WB←MEM.
  - The EX shadow also holds rs1 and rs2.
- Forwarding, combinational from the shadows, evaluated per operand:
  - sel=10 if MEM.valid & MEM.regwrite & MEM.rd≠0 & MEM.rd==EX.rs.
  - Else sel=01 if the same test passes for WB.
  - Else 00.
  - x0 is never forwarded.
- FSM states: RUN, LOAD_STALL, MEM_WAIT.
  - RUN→MEM_WAIT when MEM.memop & !dmem_ready.
  - RUN→LOAD_STALL when id_valid & EX.memread & EX.rd≠0 & EX.rd∈{id_rs1,id_rs2}.
  - LOAD_STALL→RUN after exactly one cycle.
  - MEM_WAIT→RUN in the cycle dmem_ready=1; that cycle advances normally.
- Outputs per state:
  - MEM_WAIT: pc_we=0, ifid_we=0, pipe_freeze=1; shadows hold; branch_taken ignored.
  - LOAD_STALL entry cycle: pc_we=0, ifid_we=0, idex_clr=1; EX shadow loads a bubble.
- Priority, highest first: MEM_WAIT freeze > branch_taken > load-use stall.
  - branch_taken in RUN: ifid_clr=1, idex_clr=1; any concurrent load-use stall is cancelled and pc_we=1.
- Reset while in any state: returns to RUN, shadows cleared, next cycle behaves as an empty pipeline.

## Timing
- Reset values: fwd_*_sel=00, pc_we=1, ifid_we=1, ifid_clr=0, idex_clr=0, pipe_freeze=0, state RUN, all shadow valid=0.
- Selects and stall/flush outputs are combinational from registered state and the current inputs; there are no registered outputs.
- Forwarding latency is 0 cycles: selects are valid in the same cycle the consumer is in EX.
- A load-use hazard costs exactly 1 bubble; the consumer then receives sel=01 from WB.
- A memory wait of N cycles with dmem_ready low freezes the pipeline for exactly N cycles.
- Simultaneous load-use and branch: the branch wins and no stall is taken.

## Configuration
- HAZARD_FWD_EN defined: forwarding as above.
- Undefined:
  - fwd_*_sel are tied to 00.
  - Any RAW match of id_rs1/id_rs2 against a valid regwrite EX or MEM shadow with rd≠0 stalls exactly like LOAD_STALL.
  - The stall repeats each cycle while the match persists.
  - WB needs no stall because the regfile is write-first.

## Structure
- Package riscv_pipe_pkg holds:
  - fwd_sel_t enum (FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10)
  - hz_state_t enum
  - a stage_shadow_t struct
  - the REG_AW constant
- One sub-module, fwd_compare: purely combinational; takes one source index plus the MEM and WB shadows and returns a fwd_sel_t. It is instantiated twice.

## Test plan
- EX/MEM add x5 then consumer `add x6,x5,x1`: fwd_a_sel=10, no stall. Consumer two instructions later: fwd_a_sel=01.
- `ld x7,0(x2)` then `add x8,x7,x7`: one cycle with pc_we=0 and idex_clr=1, then fwd_a_sel=fwd_b_sel=01.
- Write x0 followed by a consumer of x0: selects remain 00.
- Store in MEM with dmem_ready low for 3 cycles: pipe_freeze=1 for exactly 3 cycles. Shadows unchanged, and a branch_taken pulse during the wait causes no flush.
- Load-use hazard with branch_taken in the same cycle: ifid_clr=idex_clr=1 and pc_we=1, followed by RUN.
- rst_n=0 for one cycle during MEM_WAIT: all outputs return to their reset values next cycle. Without HAZARD_FWD_EN, `add x5` then `add x6,x5,x1` gives 2 stall cycles.
